// File: rtl/tick_timer_pkg.sv
// Shared types and default widths for the tick-driven countdown timer.
package tick_timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} timer_state_t;

  localparam int DIV_W_DEFAULT = 32;
  localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/tap_edge_detect.sv
// Selects one divider tap and turns its rising edges into registered
// single-cycle tick enables in the input_clock domain.
module tap_edge_detect #(
  parameter int DIV_W = 32,
  parameter int SEL_W = 5
) (
  input  logic             input_clock,
  input  logic             reset,
  input  logic [DIV_W-1:0] divided_clocks,
  input  logic [SEL_W-1:0] tap_sel,
  output logic             tick
);

  logic             tap_now;
  logic             tap_prev;
  logic [SEL_W-1:0] sel_q;

  // Out-of-range selections read as a constant 0 so they never tick.
  always_comb begin
    tap_now = 1'b0;
    if (32'(tap_sel) < DIV_W) tap_now = divided_clocks[tap_sel];
  end

  // A selection change masks the edge compare for one cycle, since tap_prev
  // still holds the old tap's level.
  always_ff @(posedge input_clock) begin
    if (reset) begin
      tap_prev <= 1'b0;
      sel_q    <= '0;
      tick     <= 1'b0;
    end else begin
      tap_prev <= tap_now;
      sel_q    <= tap_sel;
      tick     <= tap_now & ~tap_prev & (tap_sel == sel_q);
    end
  end

endmodule

// File: rtl/tick_countdown_timer.sv
// Loadable countdown timer clocked by ticks from a selected divider tap.
// Define TICK_TIMER_AUTO_RELOAD_EN to make expiry in RUN reload and keep running.
module tick_countdown_timer
  import tick_timer_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT,
  parameter int SEL_W = 5,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             input_clock,
  input  logic             reset,
  input  logic [DIV_W-1:0] divided_clocks,
  input  logic [SEL_W-1:0] tap_sel,
  input  logic [CNT_W-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  output logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done
);

  timer_state_t state;
  logic         start_pend;
  logic         take_start;
  logic         load_zero;

  tap_edge_detect #(
    .DIV_W (DIV_W),
    .SEL_W (SEL_W)
  ) u_tap_edge_detect (
    .input_clock    (input_clock),
    .reset          (reset),
    .divided_clocks (divided_clocks),
    .tap_sel        (tap_sel),
    .tick           (tick)
  );

  // A start seen while in DONE is remembered and acted on from IDLE.
  always_comb begin
    load_zero  = (load_value == '0);
    take_start = 1'b0;
    case (state)
      IDLE:        take_start = start | start_pend;
      RUN, PAUSED: take_start = start;
      default:     take_start = 1'b0;
    endcase
  end

  always_ff @(posedge input_clock) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      start_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      if (take_start) begin
        start_pend <= 1'b0;
        if (load_zero) begin
          state <= DONE;
          count <= '0;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state <= RUN;
          count <= load_value;
          busy  <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: ;
          RUN: begin
            if (pause) begin
              state <= PAUSED;
            end else if (tick && count == CNT_W'(1)) begin
              done <= 1'b1;
`ifdef TICK_TIMER_AUTO_RELOAD_EN
              if (!load_zero) begin
                count <= load_value;
              end else begin
                state <= DONE;
                count <= '0;
                busy  <= 1'b0;
              end
`else
              state <= DONE;
              count <= '0;
              busy  <= 1'b0;
`endif
            end else if (tick && count != '0) begin
              count <= count - CNT_W'(1);
            end
          end
          PAUSED: begin
            if (!pause) state <= RUN;
          end
          DONE: begin
            state <= IDLE;
            if (start) start_pend <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tick_countdown_timer.sv
// Directed bench for tick_countdown_timer with a free-running divider model.
module tb_tick_countdown_timer;

  localparam int DIV_W = 32;
  localparam int SEL_W = 5;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [DIV_W-1:0] div_cnt;
  logic [SEL_W-1:0] tap_sel = '0;
  logic [CNT_W-1:0] load_value = '0;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic             tick;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (reset) div_cnt <= '0;
    else       div_cnt <= div_cnt + 1'b1;
  end

  tick_countdown_timer #(
    .DIV_W (DIV_W),
    .SEL_W (SEL_W),
    .CNT_W (CNT_W)
  ) dut (
    .input_clock    (clk),
    .reset          (reset),
    .divided_clocks (div_cnt),
    .tap_sel        (tap_sel),
    .load_value     (load_value),
    .start          (start),
    .pause          (pause),
    .tick           (tick),
    .count          (count),
    .busy           (busy),
    .done           (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tick(input string tag, input int max);
    int i;
    i = 0;
    while (!tick && i < max) begin
      step(1);
      i++;
    end
    check(tag, 32'(tick), 1);
  endtask

  task automatic wait_count(input string tag, input logic [CNT_W-1:0] v, input int max);
    int i;
    i = 0;
    while (count != v && i < max) begin
      step(1);
      i++;
    end
    check(tag, 32'(count), 32'(v));
  endtask

  task automatic tick_gap(input string tag, output int gap);
    wait_tick(tag, 32);
    step(1);
    gap = 1;
    while (!tick && gap < 64) begin
      step(1);
      gap++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, n, ones, dn, bad, seen, busy_all, i;

    // reset held with start asserted
    reset = 1'b1; start = 1'b1; load_value = 16'd5; tap_sel = '0;
    step(2);
    check("rst_tick", 32'(tick), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_count", 32'(count), 0);
    reset = 1'b0; start = 1'b0;
    step(6);
    check("idle_busy", 32'(busy), 0);
    check("idle_count", 32'(count), 0);
    check("idle_done", 32'(done), 0);

    // tap 0 ticks every 2 cycles
    tick_gap("t0_first", g);
    check("t0_period", 32'(g), 2);
    ones = 0;
    for (int k = 0; k < 16; k++) begin
      step(1);
      if (tick) ones++;
    end
    check("t0_rate", 32'(ones), 8);

    // switch to tap 2 at a moment where an unmasked compare would fire
    i = 0;
    while (!(div_cnt[2] && div_cnt[0]) && i < 16) begin
      step(1);
      i++;
    end
    tap_sel = 5'd2;
    step(1);
    check("sw_no_tick", 32'(tick), 0);
    tick_gap("t2_first", g);
    check("t2_period", 32'(g), 8);

    // one-shot countdown from 3
    tap_sel = '0;
    step(2);
    load_value = 16'd3; start = 1'b1;
    step(1);
    start = 1'b0; load_value = '0;
    check("cd_busy", 32'(busy), 1);
    check("cd_load", 32'(count), 3);
    wait_tick("cd_t1", 4); step(1);
    check("cd_cnt2", 32'(count), 2);
    wait_tick("cd_t2", 4); step(1);
    check("cd_cnt1", 32'(count), 1);
    wait_tick("cd_t3", 4); step(1);
    check("cd_cnt0", 32'(count), 0);
    check("cd_done", 32'(done), 1);
    check("cd_busy_lo", 32'(busy), 0);
    step(1);
    check("cd_done_1cyc", 32'(done), 0);
    step(3);
    check("cd_idle_busy", 32'(busy), 0);
    check("cd_idle_cnt", 32'(count), 0);

    // load of zero expires immediately
    load_value = '0; start = 1'b1;
    step(1);
    start = 1'b0;
    check("z_done", 32'(done), 1);
    check("z_count", 32'(count), 0);
    check("z_busy", 32'(busy), 0);
    step(1);
    check("z_done_1cyc", 32'(done), 0);
    step(1);
    check("z_idle_busy", 32'(busy), 0);

    // pause holds the count, release resumes
    load_value = 16'd10; start = 1'b1;
    step(1);
    start = 1'b0; load_value = '0;
    wait_count("pz_reach7", 16'd7, 40);
    pause = 1'b1;
    step(20);
    check("pz_hold", 32'(count), 7);
    check("pz_busy", 32'(busy), 1);
    pause = 1'b0;
    i = 0;
    while (count == 16'd7 && i < 10) begin
      step(1);
      i++;
    end
    check("pz_resume", 32'(count), 6);

    // restart mid-count with a new load
    wait_count("rs_reach5", 16'd5, 20);
    load_value = 16'd4; start = 1'b1;
    step(1);
    start = 1'b0; load_value = '0;
    check("rs_reload", 32'(count), 4);
    n = 0; seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      if (tick) n++;
      step(1);
      if (done) seen = 1;
    end
    check("rs_ticks", 32'(n), 4);
    check("rs_done", 32'(seen), 1);
    step(2);

    // reset in the middle of a run
    load_value = 16'd10; start = 1'b1;
    step(1);
    start = 1'b0;
    wait_count("mr_reach5", 16'd5, 40);
    reset = 1'b1;
    step(1);
    check("mr_count", 32'(count), 0);
    check("mr_busy", 32'(busy), 0);
    check("mr_done", 32'(done), 0);
    reset = 1'b0;
    step(2);
    check("mr_no_done", 32'(done), 0);
    check("mr_idle", 32'(busy), 0);

    // expiry with load_value held at 2
    step(2);
    load_value = 16'd2; start = 1'b1;
    step(1);
    start = 1'b0;
    dn = 0; bad = 0; busy_all = 1;
    for (int k = 0; k < 16; k++) begin
      if (done) dn++;
      if (!busy) busy_all = 0;
      if (count != 16'd1 && count != 16'd2) bad++;
      step(1);
    end
`ifdef TICK_TIMER_AUTO_RELOAD_EN
    check("ar_dones", 32'(dn), 4);
    check("ar_busy", 32'(busy_all), 1);
    check("ar_count_seq", 32'(bad), 0);
`else
    check("os_dones", 32'(dn), 1);
    check("os_busy_end", 32'(busy), 0);
    check("os_count_end", 32'(count), 0);
`endif

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
